// File: rtl/iter_alu_if.sv
// iter_alu_if: handshake and data bundle between an operand source / result
// consumer (master) and the iterative ALU (slave).
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUop;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       status;
  logic             illegal;

  modport master (
    output in_valid, ALUop, Ain, Bin, out_ready,
    input  in_ready, out_valid, out, status, illegal
  );

  modport slave (
    input  in_valid, ALUop, Ain, Bin, out_ready,
    output in_ready, out_valid, out, status, illegal
  );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle RV32I register-register ALU with an optional iterative
// RV32M multiply/divide unit (enabled by defining ITER_ALU_MULDIV_EN).
// IDLE accepts an op; single-cycle ops go straight to DONE, M ops spend
// WIDTH shift-add / restoring-subtract steps plus one sign-fixup cycle in CALC.
// status = {NEGATIVE, OVERFLOW, ZERO}; OVERFLOW only reported for ADD/SUB.
module iter_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  iter_alu_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pack the status vector for a result.
  function automatic logic [2:0] mk_status(input logic [WIDTH-1:0] res, input logic ovf);
    mk_status = {res[WIDTH-1], ovf, (res == {WIDTH{1'b0}})};
  endfunction

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic [2:0]       status_r;
  logic             illegal_r;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic [WIDTH-1:0] b_op_s;
  logic             cin_s;
  logic [WIDTH-1:0] low_sum_s;
  logic [WIDTH:0]   addsub_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_mop_s;

  assign is_mop_s = (bus.ALUop >= OP_MUL);

  // Single-cycle RV32I result and ADD/SUB signed overflow from the live inputs.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    shamt_s   = bus.Bin[SHW-1:0];
    cin_s     = (bus.ALUop == OP_SUB);
    if (bus.ALUop == OP_SUB) begin
      b_op_s = ~bus.Bin;
    end else begin
      b_op_s = bus.Bin;
    end
    low_sum_s = {1'b0, bus.Ain[WIDTH-2:0]} + {1'b0, b_op_s[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin_s};
    addsub_s  = {1'b0, bus.Ain} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
    case (bus.ALUop)
      OP_ADD, OP_SUB: begin
        alu_res_s = addsub_s[WIDTH-1:0];
        alu_ovf_s = low_sum_s[WIDTH-1] ^ addsub_s[WIDTH];
      end
      OP_AND:  alu_res_s = bus.Ain & bus.Bin;
      OP_OR:   alu_res_s = bus.Ain | bus.Bin;
      OP_XOR:  alu_res_s = bus.Ain ^ bus.Bin;
      OP_SLL:  alu_res_s = bus.Ain << shamt_s;
      OP_SRL:  alu_res_s = bus.Ain >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(bus.Ain) >>> shamt_s);
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.Ain) < $signed(bus.Bin))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.Ain < bus.Bin)};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef ITER_ALU_MULDIV_EN
  localparam logic [3:0]   OP_MULHU = 4'd11;
  localparam logic [3:0]   OP_DIV   = 4'd12;
  localparam logic [3:0]   OP_DIVU  = 4'd13;
  localparam logic [3:0]   OP_REM   = 4'd14;
  localparam logic [3:0]   OP_REMU  = 4'd15;
  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH);

  logic [3:0]       op_r;
  logic [SHW:0]     count_r;
  logic [WIDTH-1:0] hi_r;     // multiply: product high half; divide: partial remainder
  logic [WIDTH-1:0] lo_r;     // multiply: multiplier/product low; divide: dividend/quotient
  logic [WIDTH-1:0] opnd_r;   // multiplicand or divisor magnitude
  logic             neg_q_r;
  logic             neg_r_r;
  logic             divz_r;

  logic             sgn_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             is_mul_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] hi_nxt_s;
  logic [WIDTH-1:0] lo_nxt_s;
  logic [WIDTH-1:0] md_res_s;

  // Operand magnitudes for signed divide/remainder at accept time.
  always_comb begin
    sgn_s = (bus.ALUop == OP_DIV) || (bus.ALUop == OP_REM);
    if (sgn_s && bus.Ain[WIDTH-1]) begin
      mag_a_s = {WIDTH{1'b0}} - bus.Ain;
    end else begin
      mag_a_s = bus.Ain;
    end
    if (sgn_s && bus.Bin[WIDTH-1]) begin
      mag_b_s = {WIDTH{1'b0}} - bus.Bin;
    end else begin
      mag_b_s = bus.Bin;
    end
  end

  // One shift-add multiply step or one restoring-divide step.
  always_comb begin
    is_mul_s    = (op_r == OP_MUL) || (op_r == OP_MULHU);
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (is_mul_s) begin
      hi_nxt_s = mul_sum_s[WIDTH:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end else if (!div_diff_s[WIDTH]) begin
      hi_nxt_s = div_diff_s[WIDTH-1:0];
      lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt_s = div_shift_s[WIDTH-1:0];
      lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Final M-op result with sign fixup and divide-by-zero override.
  always_comb begin
    md_res_s = {WIDTH{1'b0}};
    case (op_r)
      OP_MUL:   md_res_s = lo_r;
      OP_MULHU: md_res_s = hi_r;
      OP_DIV, OP_DIVU: begin
        if (divz_r) begin
          md_res_s = {WIDTH{1'b1}};
        end else if (neg_q_r) begin
          md_res_s = {WIDTH{1'b0}} - lo_r;
        end else begin
          md_res_s = lo_r;
        end
      end
      OP_REM, OP_REMU: begin
        if (neg_r_r) begin
          md_res_s = {WIDTH{1'b0}} - hi_r;
        end else begin
          md_res_s = hi_r;
        end
      end
      default: md_res_s = {WIDTH{1'b0}};
    endcase
  end
`endif

  // Control FSM with registered handshake, result, status and illegal outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      status_r    <= 3'b000;
      illegal_r   <= 1'b0;
`ifdef ITER_ALU_MULDIV_EN
      op_r        <= 4'd0;
      count_r     <= {(SHW+1){1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      divz_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            if (is_mop_s) begin
`ifdef ITER_ALU_MULDIV_EN
              state_r <= CALC;
              op_r    <= bus.ALUop;
              count_r <= {(SHW+1){1'b0}};
              hi_r    <= {WIDTH{1'b0}};
              if (bus.ALUop == OP_MUL || bus.ALUop == OP_MULHU) begin
                lo_r   <= bus.Bin;
                opnd_r <= bus.Ain;
              end else begin
                lo_r   <= mag_a_s;
                opnd_r <= mag_b_s;
              end
              neg_q_r <= sgn_s & (bus.Ain[WIDTH-1] ^ bus.Bin[WIDTH-1]);
              neg_r_r <= sgn_s & bus.Ain[WIDTH-1];
              divz_r  <= (bus.Bin == {WIDTH{1'b0}});
`else
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              out_r       <= {WIDTH{1'b0}};
              status_r    <= 3'b001;
              illegal_r   <= 1'b1;
`endif
            end else begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              out_r       <= alu_res_s;
              status_r    <= mk_status(alu_res_s, alu_ovf_s);
              illegal_r   <= 1'b0;
            end
          end
        end
`ifdef ITER_ALU_MULDIV_EN
        CALC: begin
          if (count_r == LAST_STEP) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            out_r       <= md_res_s;
            status_r    <= mk_status(md_res_s, 1'b0);
            illegal_r   <= 1'b0;
          end else begin
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            count_r <= count_r + {{SHW{1'b0}}, 1'b1};
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.status    = status_r;
  assign bus.illegal   = illegal_r;

endmodule
